// File: rtl/tessent_data_mux_seq.sv
// Registered multi-lane functional/IJTAG data mux with a SAFE_VALUE blanking window on every mode change.
// Optional saturating switch counter output: define TESSENT_DATA_MUX_SWITCH_COUNT_EN.
module tessent_data_mux_seq #(
    parameter int                NUM_CH       = 4,
    parameter int                WIDTH        = 3,
    parameter int                BLANK_CYCLES = 2,
    parameter logic [WIDTH-1:0]  SAFE_VALUE   = '0
) (
    input  logic                      ijtag_tck,
    input  logic                      ijtag_reset,
    input  logic                      ijtag_ue,
    input  logic [NUM_CH-1:0]         ijtag_select_req,
    input  logic [NUM_CH*WIDTH-1:0]   functional_data_in,
    input  logic [NUM_CH*WIDTH-1:0]   ijtag_data_in,
    output logic [NUM_CH*WIDTH-1:0]   data_out,
    output logic [NUM_CH-1:0]         select_active,
    output logic                      busy
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
    ,
    output logic [7:0]                switch_count
`endif
);

    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_INIT = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        FUNC,
        BLANK_TO_IJ,
        IJTAG,
        BLANK_TO_FN
    } lane_state_e;

    lane_state_e               state_q [NUM_CH];
    lane_state_e               state_d [NUM_CH];
    logic [CNT_W-1:0]          cnt_q   [NUM_CH];
    logic [CNT_W-1:0]          cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]         target_q, target_d;
    logic [NUM_CH*WIDTH-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]         select_q, select_d;
    logic                      busy_q, busy_d;

`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
    logic [7:0]                switch_count_q, switch_count_d;
    logic [31:0]               entries;
    logic [31:0]               count_sum;
`endif

    always_comb begin
        // target_d doubles as the effective request for this edge
        target_d = ijtag_ue ? ijtag_select_req : target_q;
        data_d   = '0;
        select_d = '0;
        busy_d   = 1'b0;
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
        entries  = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                FUNC: begin
                    data_d[i*WIDTH +: WIDTH] = functional_data_in[i*WIDTH +: WIDTH];
                    if (target_d[i]) begin
                        state_d[i] = BLANK_TO_IJ;
                        cnt_d[i]   = BLANK_INIT;
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
                        entries    = entries + 32'd1;
`endif
                    end
                end
                IJTAG: begin
                    data_d[i*WIDTH +: WIDTH] = ijtag_data_in[i*WIDTH +: WIDTH];
                    if (!target_d[i]) begin
                        state_d[i] = BLANK_TO_FN;
                        cnt_d[i]   = BLANK_INIT;
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
                        entries    = entries + 32'd1;
`endif
                    end
                end
                BLANK_TO_IJ, BLANK_TO_FN: begin
                    // A blank always runs to completion; a reversed request is handled after landing
                    data_d[i*WIDTH +: WIDTH] = SAFE_VALUE;
                    busy_d = 1'b1;
                    if (cnt_q[i] == '0) begin
                        state_d[i] = (state_q[i] == BLANK_TO_IJ) ? IJTAG : FUNC;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = FUNC;
                    data_d[i*WIDTH +: WIDTH] = SAFE_VALUE;
                end
            endcase
            select_d[i] = (state_d[i] == IJTAG);
        end
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
        count_sum      = 32'(switch_count_q) + entries;
        switch_count_d = (count_sum > 32'd255) ? 8'd255 : count_sum[7:0];
`endif
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= FUNC;
                cnt_q[i]   <= '0;
            end
            target_q <= '0;
            data_q   <= {NUM_CH{SAFE_VALUE}};
            select_q <= '0;
            busy_q   <= 1'b0;
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
            switch_count_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            target_q <= target_d;
            data_q   <= data_d;
            select_q <= select_d;
            busy_q   <= busy_d;
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
            switch_count_q <= switch_count_d;
`endif
        end
    end

    assign data_out      = data_q;
    assign select_active = select_q;
    assign busy          = busy_q;
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
    assign switch_count  = switch_count_q;
`endif

endmodule

// File: tb/tb_tessent_data_mux_seq.sv
// Self-checking bench for tessent_data_mux_seq: directed scenarios plus random traffic,
// compared each edge against a timestamp-based lane model.
module tb_tessent_data_mux_seq;

    localparam int               NUM_CH       = 4;
    localparam int               WIDTH        = 3;
    localparam int               BLANK_CYCLES = 2;
    localparam int               NW           = NUM_CH * WIDTH;
    localparam logic [WIDTH-1:0] SAFE_VALUE   = 3'b000;

    logic                ijtag_tck = 1'b0;
    logic                ijtag_reset;
    logic                ijtag_ue;
    logic [NUM_CH-1:0]   ijtag_select_req;
    logic [NW-1:0]       functional_data_in;
    logic [NW-1:0]       ijtag_data_in;
    logic [NW-1:0]       data_out;
    logic [NUM_CH-1:0]   select_active;
    logic                busy;
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
    logic [7:0]          switch_count;
`endif

    tessent_data_mux_seq #(
        .NUM_CH       (NUM_CH),
        .WIDTH        (WIDTH),
        .BLANK_CYCLES (BLANK_CYCLES),
        .SAFE_VALUE   (SAFE_VALUE)
    ) dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_ue           (ijtag_ue),
        .ijtag_select_req   (ijtag_select_req),
        .functional_data_in (functional_data_in),
        .ijtag_data_in      (ijtag_data_in),
        .data_out           (data_out),
        .select_active      (select_active),
        .busy               (busy)
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
        ,
        .switch_count       (switch_count)
`endif
    );

    always #5 ijtag_tck = ~ijtag_tck;

    int checks = 0;
    int errors = 0;

    // Model: each lane has a settled mode; a switch records the edge at which it lands
    int                edge_num = 0;
    bit                mode     [NUM_CH];
    bit                dest     [NUM_CH];
    bit                switching[NUM_CH];
    int                land_at  [NUM_CH];
    logic [NUM_CH-1:0] tgt;
    logic [NW-1:0]     exp_out;
    logic [NUM_CH-1:0] exp_sel;
    logic              exp_busy;
    int                exp_cnt;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_num, observed, expected);
        end
    endtask

    task automatic modelEdge();
        logic [NUM_CH-1:0] eff;
        edge_num++;
        if (ijtag_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode[i]      = 1'b0;
                switching[i] = 1'b0;
            end
            tgt      = '0;
            exp_out  = {NUM_CH{SAFE_VALUE}};
            exp_sel  = '0;
            exp_busy = 1'b0;
            exp_cnt  = 0;
            return;
        end
        eff = ijtag_ue ? ijtag_select_req : tgt;
        if (ijtag_ue) tgt = ijtag_select_req;
        exp_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (switching[i]) begin
                exp_out[i*WIDTH +: WIDTH] = SAFE_VALUE;
                exp_busy = 1'b1;
                if (edge_num == land_at[i]) begin
                    switching[i] = 1'b0;
                    mode[i]      = dest[i];
                end
            end else begin
                exp_out[i*WIDTH +: WIDTH] = mode[i] ? ijtag_data_in[i*WIDTH +: WIDTH]
                                                    : functional_data_in[i*WIDTH +: WIDTH];
                if (eff[i] != mode[i]) begin
                    switching[i] = 1'b1;
                    dest[i]      = eff[i];
                    land_at[i]   = edge_num + BLANK_CYCLES;
                    if (exp_cnt < 255) exp_cnt++;
                end
            end
            exp_sel[i] = !switching[i] && mode[i];
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ue, input logic [NUM_CH-1:0] req,
                                 input logic [NW-1:0] fdata, input logic [NW-1:0] idata);
        @(negedge ijtag_tck);
        ijtag_reset        = rst;
        ijtag_ue           = ue;
        ijtag_select_req   = req;
        functional_data_in = fdata;
        ijtag_data_in      = idata;
        @(posedge ijtag_tck);
        modelEdge();
        #1;
        checkOutput("data_out", 64'(data_out), 64'(exp_out));
        checkOutput("select_active", 64'(select_active), 64'(exp_sel));
        checkOutput("busy", 64'(busy), 64'(exp_busy));
`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
        checkOutput("switch_count", 64'(switch_count), 64'(exp_cnt));
`endif
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 1'b0, NUM_CH'($urandom), NW'($urandom), NW'($urandom));
    endtask

    task automatic requestModes(input logic [NUM_CH-1:0] req);
        applyStimulus(1'b0, 1'b1, req, NW'($urandom), NW'($urandom));
    endtask

    initial begin
        ijtag_reset        = 1'b1;
        ijtag_ue           = 1'b0;
        ijtag_select_req   = '0;
        functional_data_in = '0;
        ijtag_data_in      = '0;

        // Reset then idle, functional lane0 = 101
        applyStimulus(1'b1, 1'b0, '0, 12'h005, 12'h000);
        applyStimulus(1'b1, 1'b0, '0, 12'h005, 12'h000);
        checkOutput("reset_lane0", 64'(data_out[2:0]), 64'(3'b000));
        applyStimulus(1'b0, 1'b0, '0, 12'h005, 12'h000);
        checkOutput("release_lane0", 64'(data_out[2:0]), 64'(3'b101));

        // Switch lane0 to IJTAG, ijtag lane0 = 011
        applyStimulus(1'b0, 1'b1, 4'b0001, 12'h005, 12'h003);
        checkOutput("edge0_functional", 64'(data_out[2:0]), 64'(3'b101));
        applyStimulus(1'b0, 1'b0, '0, 12'h005, 12'h003);
        checkOutput("edge1_safe", 64'(data_out[2:0]), 64'(3'b000));
        applyStimulus(1'b0, 1'b0, '0, 12'h005, 12'h003);
        checkOutput("edge2_select", 64'(select_active[0]), 64'(1'b1));
        applyStimulus(1'b0, 1'b0, '0, 12'h005, 12'h003);
        checkOutput("edge3_ijtag", 64'(data_out[2:0]), 64'(3'b011));
        checkOutput("edge3_busy", 64'(busy), 64'(1'b0));

        requestModes(4'b0000);
        idleCycles(4);

        // Independent lanes
        requestModes(4'b1010);
        idleCycles(5);
        requestModes(4'b0000);
        idleCycles(5);

        // Request reversal mid-blank
        requestModes(4'b0001);
        requestModes(4'b0000);
        idleCycles(7);

        // Reset mid-blank
        requestModes(4'b0001);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 4'b0001, NW'($urandom), NW'($urandom));
        checkOutput("reset_midblank_busy", 64'(busy), 64'(1'b0));
        applyStimulus(1'b0, 1'b0, '0, 12'h006, 12'h001);
        checkOutput("post_reset_functional", 64'(data_out[2:0]), 64'(3'b110));
        idleCycles(3);

`ifdef TESSENT_DATA_MUX_SWITCH_COUNT_EN
        // 64 toggles of all four lanes saturates the counter
        for (int k = 0; k < 64; k++) begin
            requestModes((k % 2 == 0) ? 4'b1111 : 4'b0000);
            idleCycles(BLANK_CYCLES);
        end
        checkOutput("count_saturated", 64'(switch_count), 64'(8'd255));
        requestModes(4'b1111);
        idleCycles(BLANK_CYCLES);
        checkOutput("count_holds", 64'(switch_count), 64'(8'd255));
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        checkOutput("count_reset", 64'(switch_count), 64'(8'd0));
`endif

        // Random traffic
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        for (int k = 0; k < 500; k++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                          NUM_CH'($urandom), NW'($urandom), NW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
